// File: rtl/inst_sram_axi_rd_bridge_if.sv
// rtl/inst_sram_axi_rd_bridge_if.sv - fetch-side SRAM-like port plus AXI4 read channels
interface inst_sram_axi_rd_bridge_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        inst_sram_data_err;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, inst_sram_data_err,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, inst_sram_data_err,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/inst_sram_axi_rd_bridge.sv
// rtl/inst_sram_axi_rd_bridge.sv - SRAM-like instruction fetch to single-beat AXI4 read bridge
module inst_sram_axi_rd_bridge #(
    parameter logic [3:0] AXI_ID  = 4'd0,
    parameter int         MAX_OUT = 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    inst_sram_axi_rd_bridge_if.master     bus
);
    localparam logic [2:0] MAX_CNT = 3'(MAX_OUT);

    typedef enum logic {AR_IDLE, AR_PEND} ar_state_t;

    ar_state_t   ar_state;
    ar_state_t   ar_state_next;
    logic        ar_pend;
    logic [2:0]  cnt;
    logic [31:0] araddr_q;
    logic [1:0]  size_q;
    logic        data_ok_q;
    logic [31:0] rdata_q;
    logic        data_err_q;
    logic        addr_ok;
    logic        r_hs;

    // A new request is only taken once the previous AR has handshaken.
    assign addr_ok = bus.inst_sram_req && !ar_pend && (cnt < MAX_CNT);
    assign r_hs    = bus.rvalid && bus.rready;

    always_ff @(posedge clk) begin
        if (!resetn) ar_state <= AR_IDLE;
        else         ar_state <= ar_state_next;
    end

    always_comb begin
        ar_state_next = ar_state;
        case (ar_state)
            AR_IDLE: if (addr_ok)     ar_state_next = AR_PEND;
            AR_PEND: if (bus.arready) ar_state_next = AR_IDLE;
            default:                  ar_state_next = AR_IDLE;
        endcase
    end

    always_comb begin
        ar_pend = (ar_state == AR_PEND);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt        <= 3'd0;
            araddr_q   <= 32'd0;
            size_q     <= 2'b10;
            data_ok_q  <= 1'b0;
            rdata_q    <= 32'd0;
            data_err_q <= 1'b0;
        end else begin
            if (addr_ok) begin
                araddr_q <= bus.inst_sram_addr;
                size_q   <= bus.inst_sram_size;
            end
            case ({addr_ok, r_hs})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
            data_ok_q <= r_hs;
            if (r_hs) begin
                rdata_q    <= bus.rdata;
                data_err_q <= bus.rresp[1];
            end
        end
    end

    // Write flag, rid, rlast and the OKAY/EXOKAY distinction carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, bus.inst_sram_wr, bus.rid, bus.rlast, bus.rresp[0]};

    assign bus.inst_sram_addr_ok  = addr_ok;
    assign bus.inst_sram_data_ok  = data_ok_q;
    assign bus.inst_sram_rdata    = rdata_q;
    assign bus.inst_sram_data_err = data_err_q;

    assign bus.arid    = AXI_ID;
    assign bus.araddr  = araddr_q;
    assign bus.arlen   = 8'd0;
    assign bus.arsize  = {1'b0, size_q};
    assign bus.arburst = 2'b01;
    assign bus.arlock  = 2'b00;
    assign bus.arcache = 4'd0;
    assign bus.arprot  = 3'd0;
    assign bus.arvalid = ar_pend;
    assign bus.rready  = (cnt != 3'd0);
endmodule

// File: doc/inst_sram_axi_rd_bridge.md
Name: inst_sram_axi_rd_bridge

Overview:
Converts the instruction-side SRAM-like request interface driven by the fetch stage into single-beat AXI4 read transactions toward the memory system. It sits directly downstream of the fetch stage's inst_sram port and returns the fetched words on data_ok. It is read-only. Responses come back in order, with up to MAX_OUT transactions outstanding.

Parameters:
AXI_ID, 4'd0, constant arid driven on every read request
MAX_OUT, 2, maximum accepted-but-unreturned requests (1..7)

Ports:
clk  input  1  clock
resetn  input  1  reset, synchronous, active-low
inst_sram_req  input  1  request valid from fetch
inst_sram_wr  input  1  write flag; ignored (bridge is read-only)
inst_sram_size  input  2  log2 bytes (2'b10 = word)
inst_sram_addr  input  32  physical fetch address
inst_sram_addr_ok  output  1  request accepted this cycle
inst_sram_data_ok  output  1  read data valid this cycle
inst_sram_rdata  output  32  read data
inst_sram_data_err  output  1  qualifies data_ok: AXI rresp was SLVERR/DECERR
arid  output  4  = AXI_ID
araddr  output  32  registered request address
arlen  output  8  constant 0
arsize  output  3  {1'b0, latched size}
arburst  output  2  constant 2'b01
arlock  output  2  constant 0
arcache  output  4  constant 0
arprot  output  3  constant 0
arvalid  output  1  AR valid
arready  input  1  AR ready
rid  input  4  ignored
rdata  input  32  R data
rresp  input  2  R response
rlast  input  1  ignored (single beat)
rvalid  input  1  R valid
rready  output  1  R ready

Behaviour:
- State:
  - cnt (3 bits): accepted-but-unreturned request count.
  - ar_pend: arvalid register.
  - Registers for araddr/arsize.
  - Registers for data_ok/rdata/data_err.
- addr_ok = inst_sram_req && !ar_pend && (cnt < MAX_OUT). Purely combinational on current state. Does not depend on arready.
- On the addr_ok cycle N:
  - latch addr and size;
  - ar_pend <= 1, so arvalid = 1 from N+1.
- arvalid is held, with araddr/arsize stable, until the cycle arvalid && arready. ar_pend clears the following edge.
  - Consequence: at most one new request is accepted per AR handshake. Back-to-back accept is therefore possible only every 2 cycles with arready = 1.
- rready = (cnt != 0). An rvalid arriving with cnt == 0 is not accepted (protocol error; must not corrupt state).
- R handshake at cycle M (rvalid && rready):
  - data_ok <= 1 at M+1, for exactly one cycle per beat;
  - rdata <= rdata;
  - data_err <= (rresp[1] == 1).
- data_ok is 0 in every cycle without a preceding R handshake. The rdata output holds its last value.
- cnt update:
  - +1 on addr_ok;
  - −1 on R handshake;
  - both in the same cycle → unchanged;
  - never exceeds MAX_OUT;
  - never underflows.
- Latency: with arready and rvalid each answering the cycle after they are asked for, addr_ok at N gives arvalid at N+1, R at N+2 and data_ok at N+3.
- Ordering: responses are delivered in AR issue order. rid is not checked.
- inst_sram_wr = 1 is treated as a read. No write channel exists.
- Reset values:
  - cnt = 0;
  - arvalid = 0;
  - araddr = 0;
  - arsize = 3'b010;
  - data_ok = 0;
  - rdata = 0;
  - data_err = 0;
  - rready = 0 (derived).
- Reset mid-operation: all outstanding transactions are dropped, arvalid deasserts immediately at the reset edge, and no data_ok is produced for them. The interconnect is reset together with this block.
- The bridge has no cancel input. Fetch-side cancels are handled by the fetch stage consuming and discarding data_ok.

Test Plan:
- Single fetch: req at cycle 0 with addr 0x1c000000, arready = 1, rvalid at cycle 2 with rdata 0x02800000 and rresp 0 → addr_ok at 0, arvalid with araddr 0x1c000000 and arsize 3'b010 at 1, data_ok with rdata 0x02800000 and data_err = 0 at 3, cnt back to 0.
- AR backpressure: arready = 0 for 5 cycles after accept → arvalid and araddr stay stable for 5 cycles, addr_ok = 0 for new reqs throughout, handshake on cycle 6 → ar_pend clears.
- Outstanding limit (MAX_OUT = 2): continuous req with arready = 1 and R withheld → two accepts (cycles 0, 2), cnt = 2, addr_ok = 0 thereafter. One R beat → cnt = 1 and addr_ok reasserts next cycle.
- Simultaneous accept and return at cnt = 1 → cnt stays 1. Two responses 0x11111111 then 0x22222222 → data_ok twice, in that order.
- Error response: rresp = 2'b10 → data_ok with data_err = 1. Stray rvalid with cnt = 0 → rready = 0, no data_ok.
- Reset with cnt = 2 and arvalid = 1 → next cycle arvalid = 0, cnt = 0, and late rvalid is not accepted.
